// File: rtl/prco_lsu_wb_pkg.sv
// Shared definitions for the LSU/write-back stage: ISA load/store opcodes, FSM encoding, abort fill.
// The optional ack watchdog is enabled by defining PRCO_LSU_TIMEOUT_EN.
package prco_lsu_wb_pkg;

    localparam logic [4:0]  PRCO_OP_LW      = 5'h0c;
    localparam logic [4:0]  PRCO_OP_SW      = 5'h0d;
    localparam logic [15:0] PRCO_ABORT_FILL = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_WB       = 2'd3
    } lsu_state_e;

    // Anything that is not an explicit store is handled as a load.
    function automatic logic is_store(input logic [4:0] op);
        return op == PRCO_OP_SW;
    endfunction

endpackage

// File: rtl/prco_lsu_req.sv
// RAM request/ack register: holds req and its fields stable until ack.
// With PRCO_LSU_TIMEOUT_EN defined it also runs the ack watchdog.
module prco_lsu_req #(
    parameter int ADDR_W = 16
`ifdef PRCO_LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_wdata,
    input  logic              i_mem_ack,
    output logic              q_mem_req,
    output logic              q_mem_we,
    output logic [ADDR_W-1:0] q_mem_addr,
    output logic [15:0]       q_mem_wdata,
    output logic              q_done
`ifdef PRCO_LSU_TIMEOUT_EN
    ,
    output logic              q_timeout
`endif
);

    // Ack only counts while a request is outstanding; stray acks fall through.
    assign q_done = q_mem_req && i_mem_ack;

`ifdef PRCO_LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_cnt_reg;

    assign q_timeout = q_mem_req && !i_mem_ack &&
                       (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt_reg <= '0;
        end else if (!q_mem_req || i_mem_ack || q_timeout) begin
            wd_cnt_reg <= '0;
        end else begin
            wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_mem_req   <= 1'b0;
            q_mem_we    <= 1'b0;
            q_mem_addr  <= '0;
            q_mem_wdata <= '0;
        end else if (i_load) begin
            q_mem_req   <= 1'b1;
            q_mem_we    <= i_we;
            q_mem_addr  <= i_addr;
            q_mem_wdata <= i_wdata;
        end else if (q_done) begin
            q_mem_req   <= 1'b0;
`ifdef PRCO_LSU_TIMEOUT_EN
        end else if (q_timeout) begin
            q_mem_req   <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/prco_lsu_wb.sv
// Memory-access / write-back stage: runs LW/SW over a req/ack RAM port, then writes back or redirects fetch.
// Define PRCO_LSU_TIMEOUT_EN to add the ack watchdog and the q_mem_err output.
module prco_lsu_wb
    import prco_lsu_wb_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int REG_SEL_W = 3
`ifdef PRCO_LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ce_ram,
    input  logic                 i_ce_reg,
    input  logic                 i_should_branch,
    input  logic [4:0]           i_op,
    input  logic [15:0]          i_result,
    input  logic [15:0]          i_store_data,
    input  logic [REG_SEL_W-1:0] i_dest_sel,
    output logic                 q_mem_req,
    output logic                 q_mem_we,
    output logic [ADDR_W-1:0]    q_mem_addr,
    output logic [15:0]          q_mem_wdata,
    input  logic                 i_mem_ack,
    input  logic [15:0]          i_mem_rdata,
    output logic                 q_reg_we,
    output logic [REG_SEL_W-1:0] q_reg_sel,
    output logic [15:0]          q_reg_data,
    output logic                 q_branch,
    output logic [15:0]          q_branch_pc,
    output logic                 q_stall,
    output logic                 q_ce_fetch
`ifdef PRCO_LSU_TIMEOUT_EN
    ,
    output logic                 q_mem_err
`endif
);

    lsu_state_e state_reg, state_next;

    logic [4:0]           op_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [15:0]          store_reg;
    logic [REG_SEL_W-1:0] dest_reg;
    logic [15:0]          rdata_reg;

    logic                 reg_we_reg, reg_we_next;
    logic [REG_SEL_W-1:0] reg_sel_reg, reg_sel_next;
    logic [15:0]          reg_data_reg, reg_data_next;
    logic                 branch_reg, branch_next;
    logic [15:0]          branch_pc_reg, branch_pc_next;
    logic                 fetch_reg, fetch_next;

    logic latch_en;
    logic capture_rd;
    logic req_load;
    logic req_done;
`ifdef PRCO_LSU_TIMEOUT_EN
    logic req_timeout;
    logic err_reg, err_next;
`endif

    prco_lsu_req #(
        .ADDR_W         (ADDR_W)
`ifdef PRCO_LSU_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_req (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (req_load),
        .i_we        (is_store(op_reg)),
        .i_addr      (addr_reg),
        .i_wdata     (store_reg),
        .i_mem_ack   (i_mem_ack),
        .q_mem_req   (q_mem_req),
        .q_mem_we    (q_mem_we),
        .q_mem_addr  (q_mem_addr),
        .q_mem_wdata (q_mem_wdata),
        .q_done      (req_done)
`ifdef PRCO_LSU_TIMEOUT_EN
        ,
        .q_timeout   (req_timeout)
`endif
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // RAM wins over branch, branch wins over a plain register write.
    always_comb begin
        state_next     = state_reg;
        latch_en       = 1'b0;
        capture_rd     = 1'b0;
        req_load       = 1'b0;
        reg_we_next    = 1'b0;
        reg_sel_next   = reg_sel_reg;
        reg_data_next  = reg_data_reg;
        branch_next    = 1'b0;
        branch_pc_next = branch_pc_reg;
        fetch_next     = 1'b0;
`ifdef PRCO_LSU_TIMEOUT_EN
        err_next       = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (i_ce_ram) begin
                    latch_en   = 1'b1;
                    state_next = ST_MEM_REQ;
                end else if (i_should_branch) begin
                    branch_next    = 1'b1;
                    branch_pc_next = i_result;
                    fetch_next     = 1'b1;
                end else if (i_ce_reg) begin
                    reg_we_next   = 1'b1;
                    reg_sel_next  = i_dest_sel;
                    reg_data_next = i_result;
                    fetch_next    = 1'b1;
                end
            end
            ST_MEM_REQ: begin
                req_load   = 1'b1;
                state_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (req_done) begin
                    if (is_store(op_reg)) begin
                        fetch_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        capture_rd = 1'b1;
                        state_next = ST_WB;
                    end
`ifdef PRCO_LSU_TIMEOUT_EN
                end else if (req_timeout) begin
                    fetch_next = 1'b1;
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                    if (!is_store(op_reg)) begin
                        reg_we_next   = 1'b1;
                        reg_sel_next  = dest_reg;
                        reg_data_next = PRCO_ABORT_FILL;
                    end
`endif
                end
            end
            ST_WB: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_reg    <= '0;
            addr_reg  <= '0;
            store_reg <= '0;
            dest_reg  <= '0;
            rdata_reg <= '0;
        end else begin
            if (latch_en) begin
                op_reg    <= i_op;
                addr_reg  <= ADDR_W'(i_result);
                store_reg <= i_store_data;
                dest_reg  <= i_dest_sel;
            end
            if (capture_rd) begin
                rdata_reg <= i_mem_rdata;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            reg_we_reg    <= 1'b0;
            reg_sel_reg   <= '0;
            reg_data_reg  <= '0;
            branch_reg    <= 1'b0;
            branch_pc_reg <= '0;
            fetch_reg     <= 1'b0;
        end else begin
            reg_we_reg    <= reg_we_next;
            reg_sel_reg   <= reg_sel_next;
            reg_data_reg  <= reg_data_next;
            branch_reg    <= branch_next;
            branch_pc_reg <= branch_pc_next;
            fetch_reg     <= fetch_next;
        end
    end

`ifdef PRCO_LSU_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end

    assign q_mem_err = err_reg;
`endif

    // Loads write back from the WB state itself; everything else comes from the pulse registers.
    assign q_reg_we    = reg_we_reg || (state_reg == ST_WB);
    assign q_reg_sel   = (state_reg == ST_WB) ? dest_reg  : reg_sel_reg;
    assign q_reg_data  = (state_reg == ST_WB) ? rdata_reg : reg_data_reg;
    assign q_ce_fetch  = fetch_reg || (state_reg == ST_WB);
    assign q_branch    = branch_reg;
    assign q_branch_pc = branch_pc_reg;
    assign q_stall     = (state_reg != ST_IDLE);

endmodule

// File: doc/prco_lsu_wb.md
Name: prco_lsu_wb

Overview:
- Memory-access/write-back stage directly downstream of the ALU stage.
- Consumes the ALU result, the RAM/register enables and the branch flag. Performs the LW/SW RAM transaction with a req/ack handshake, then writes the register file or redirects fetch.
- Asserts a stall to upstream stages while a RAM transaction is outstanding.

Parameters:
- ADDR_W, 16, RAM address width; the ALU result is truncated or zero-extended to this width.
- REG_SEL_W, 3, register-file select width.
- TIMEOUT_CYCLES, 16, ack watchdog limit; used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ce_ram  in  1  ALU result is a RAM address; one-cycle pulse.
- i_ce_reg  in  1  ALU result goes to the register file; one-cycle pulse.
- i_should_branch  in  1  ALU decided the jump is taken.
- i_op  in  5  opcode carried alongside the ALU result.
- i_result  in  16  ALU result: data, address or jump target.
- i_store_data  in  16  SW source-register value.
- i_dest_sel  in  REG_SEL_W  destination register.
- q_mem_req  out  1  RAM request, held until ack.
- q_mem_we  out  1  1 = write (SW).
- q_mem_addr  out  ADDR_W  RAM address.
- q_mem_wdata  out  16  RAM write data.
- i_mem_ack  in  1  RAM completion; qualifies i_mem_rdata on reads.
- i_mem_rdata  in  16  RAM read data.
- q_reg_we  out  1  register-file write strobe, one cycle.
- q_reg_sel  out  REG_SEL_W  register-file write select.
- q_reg_data  out  16  register-file write data.
- q_branch  out  1  fetch redirect, one-cycle pulse.
- q_branch_pc  out  16  redirect target.
- q_stall  out  1  upstream hold.
- q_ce_fetch  out  1  instruction retired, one-cycle pulse.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE. Reset is asynchronous and may arrive mid-transaction. The transaction is then dropped: q_mem_req falls immediately and no q_reg_we is issued.
- FSM states: IDLE, MEM_REQ, MEM_WAIT, WB.
- IDLE, i_ce_reg=1:
  - Next cycle: q_reg_we=1, q_reg_sel=i_dest_sel, q_reg_data=i_result, q_ce_fetch=1.
  - Latency is 1 cycle. The FSM stays in IDLE.
- IDLE, i_should_branch=1:
  - Next cycle: q_branch=1, q_branch_pc=i_result, q_ce_fetch=1.
  - No register write, even if i_ce_reg is also high. Branch has priority over register write.
- IDLE, i_ce_ram=1:
  - Latch op, address, store data and dest into internal registers.
  - Go to MEM_REQ. q_stall=1 from the next cycle.
  - Opcode other than LW/SW with i_ce_ram=1: treated as LW.
- MEM_REQ:
  - Drive q_mem_req=1, with q_mem_we=(op==SW), q_mem_addr and q_mem_wdata.
  - Go to MEM_WAIT.
- MEM_WAIT:
  - Hold q_mem_req and all request fields stable until i_mem_ack.
  - On ack: deassert q_mem_req the next cycle.
  - LW on ack: capture i_mem_rdata and go to WB.
  - SW on ack: pulse q_ce_fetch and go to IDLE.
  - An ack arriving in the same cycle as the request is legal; the minimum total is 3 cycles from i_ce_ram to retire.
- WB:
  - One cycle of q_reg_we=1, q_reg_sel=latched dest, q_reg_data=read data, q_ce_fetch=1.
  - Go to IDLE.
- q_stall: 1 in MEM_REQ, MEM_WAIT and WB.
- Input enables in a non-IDLE state: ignored. Upstream must honour q_stall.
- Both i_ce_ram and i_ce_reg high: protocol violation; RAM wins.
- Spurious i_mem_ack outside MEM_WAIT: ignored.

Optional Feature:
- Macro: PRCO_LSU_TIMEOUT_EN.
- Defined:
  - A counter runs in MEM_WAIT.
  - If TIMEOUT_CYCLES elapse without ack, drop q_mem_req, return to IDLE and pulse q_ce_fetch.
  - An aborted LW writes 16'hDEAD to the destination. An aborted SW is discarded.
  - Extra output q_mem_err pulses for 1 cycle on abort and is 0 at reset.
- Undefined: MEM_WAIT waits indefinitely; no q_mem_err port exists.

Decomposition:
- Shared package/include holds:
  - the PRCO_OP_LW/PRCO_OP_SW opcode constants, from the existing ISA include;
  - FSM state encodings (2 bits);
  - the abort fill value 16'hDEAD.
- One natural sub-module, prco_lsu_req: holds the request/ack register (q_mem_req, address, wdata, we) and the watchdog counter. The parent holds the FSM and write-back mux.

Test Plan:
- Reg write: i_ce_reg=1, i_result=16'h1234, i_dest_sel=3 -> next cycle q_reg_we=1, q_reg_sel=3, q_reg_data=16'h1234, q_ce_fetch=1, q_stall=0.
- LW, ack after 4 cycles:
  - Stimulus: i_ce_ram=1, op=LW, i_result=16'h0040, dest=5; rdata=16'hBEEF with ack.
  - Response: q_mem_addr=16'h0040 and q_mem_we=0 held stable; q_reg_data=16'hBEEF to reg 5 on the cycle after ack; q_stall high throughout.
- SW, same-cycle ack: op=SW, addr 16'h0010, i_store_data=16'h00AA, ack immediately -> q_mem_we=1, q_mem_wdata=16'h00AA, no q_reg_we, q_ce_fetch exactly 3 cycles after i_ce_ram.
- Branch: i_should_branch=1 and i_ce_reg=1, i_result=16'h0100 -> q_branch=1, q_branch_pc=16'h0100, q_reg_we stays 0.
- Reset mid-wait: i_rst_n low during MEM_WAIT -> q_mem_req=0 asynchronously; after release, a late ack produces no q_reg_we.
- With PRCO_LSU_TIMEOUT_EN: LW with no ack -> after 16 cycles q_mem_err pulses, reg gets 16'hDEAD, q_stall drops.
